// File: rtl/ofdm_sym_demux.sv
// OFDM SIGNAL/payload separator: frames N_FFT-bin symbols, drops masked bins and
// routes SIGNAL-symbol data bins and payload data bins to separate registered ports.
module ofdm_sym_demux #(
  parameter int                DW        = 12,
  parameter int                N_FFT     = 64,
  parameter int                HDR_SYMS  = 1,
  parameter int                SYM_W     = 10,
  parameter logic [N_FFT-1:0]  DATA_MASK = 64'hFDFF_F7C0_07DF_FF7E
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    din_re,
  input  logic [DW-1:0]    din_im,
  input  logic             din_vld,
  input  logic             din_sof,
  input  logic [SYM_W-1:0] pld_nsym,
  output logic [DW-1:0]    dout_signal_re,
  output logic [DW-1:0]    dout_signal_im,
  output logic             dout_signal_vld,
  output logic [DW-1:0]    dout_payload_re,
  output logic [DW-1:0]    dout_payload_im,
  output logic             dout_payload_vld,
  output logic [SYM_W-1:0] dout_sym_idx,
  output logic             frame_done,
  output logic             err_sync,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for sof, samples discarded
  // SIG   | SIGNAL symbols, data bins to signal port
  // PLD   | payload symbols, data bins to payload port
  typedef enum logic [1:0] {IDLE, SIG, PLD} state_t;

  localparam int                BW       = $clog2(N_FFT);
  localparam logic [BW-1:0]     BIN_LAST = BW'(N_FFT - 1);
  localparam logic [SYM_W-1:0]  HDR_LAST = SYM_W'(HDR_SYMS - 1);

  state_t           state;
  logic [BW-1:0]    bin_cnt;
  logic [SYM_W-1:0] sym_cnt;
  logic [SYM_W-1:0] nsym_lat;

  // An accepted sof overrides the current position: the sample becomes SIG bin 0.
  logic             start;
  state_t           cur_st;
  logic [BW-1:0]    cur_bin;
  logic [SYM_W-1:0] cur_sym;
  logic [SYM_W-1:0] cur_nsym;
  logic             last_bin;
  logic             is_data;
  logic             sof_ok;
  logic             sof_err;
  logic             sig_end;
  logic             pld_end;

  always_comb begin
    start    = din_vld && din_sof;
    cur_st   = start ? SIG : state;
    cur_bin  = start ? '0 : bin_cnt;
    cur_sym  = start ? '0 : sym_cnt;
    cur_nsym = start ? pld_nsym : nsym_lat;
    last_bin = (cur_bin == BIN_LAST);
    is_data  = DATA_MASK[cur_bin];
    sof_ok   = start && (state == PLD) && (nsym_lat == '0) && (bin_cnt == '0);
    sof_err  = start && (state != IDLE) && !sof_ok;
    sig_end  = (cur_st == SIG) && last_bin && (cur_sym == HDR_LAST);
    pld_end  = (cur_st == PLD) && last_bin && (cur_nsym != '0) &&
               (cur_sym == cur_nsym - SYM_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bin_cnt          <= '0;
      sym_cnt          <= '0;
      nsym_lat         <= '0;
      dout_signal_re   <= '0;
      dout_signal_im   <= '0;
      dout_signal_vld  <= 1'b0;
      dout_payload_re  <= '0;
      dout_payload_im  <= '0;
      dout_payload_vld <= 1'b0;
      dout_sym_idx     <= '0;
      frame_done       <= 1'b0;
      err_sync         <= 1'b0;
      busy             <= 1'b0;
    end else begin
      dout_signal_vld  <= 1'b0;
      dout_payload_vld <= 1'b0;
      frame_done       <= 1'b0;
      err_sync         <= 1'b0;
      if (din_vld && (cur_st != IDLE)) begin
        if (start)
          nsym_lat <= pld_nsym;
        if (is_data) begin
          dout_sym_idx <= cur_sym;
          if (cur_st == SIG) begin
            dout_signal_re  <= din_re;
            dout_signal_im  <= din_im;
            dout_signal_vld <= 1'b1;
          end else begin
            dout_payload_re  <= din_re;
            dout_payload_im  <= din_im;
            dout_payload_vld <= 1'b1;
          end
        end
        frame_done <= sof_ok || pld_end;
        err_sync   <= sof_err;
        bin_cnt    <= last_bin ? '0 : cur_bin + BW'(1);
        if (sig_end) begin
          state   <= PLD;
          sym_cnt <= '0;
          busy    <= 1'b1;
        end else if (pld_end) begin
          state   <= IDLE;
          sym_cnt <= '0;
          busy    <= 1'b0;
        end else begin
          state   <= cur_st;
          sym_cnt <= last_bin ? cur_sym + SYM_W'(1) : cur_sym;
          busy    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ofdm_sym_demux.sv
// Directed bench for ofdm_sym_demux: default 802.11a instance plus a 16-bin,
// two-SIGNAL-symbol instance; outputs are captured and compared to built lists.
module tb_ofdm_sym_demux;

  typedef struct packed {
    logic [11:0] re;
    logic [11:0] im;
    logic [9:0]  idx;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] din_re, din_im;
  logic        din_vld, din_sof;
  logic [9:0]  pld_nsym;

  logic [11:0] a_sig_re, a_sig_im, a_pld_re, a_pld_im;
  logic        a_sig_vld, a_pld_vld, a_done, a_err, a_busy;
  logic [9:0]  a_idx;
  logic [11:0] b_sig_re, b_sig_im, b_pld_re, b_pld_im;
  logic        b_sig_vld, b_pld_vld, b_done, b_err, b_busy;
  logic [9:0]  b_idx;

  ofdm_sym_demux dut_a (
    .clk(clk), .rst(rst), .din_re(din_re), .din_im(din_im), .din_vld(din_vld),
    .din_sof(din_sof), .pld_nsym(pld_nsym),
    .dout_signal_re(a_sig_re), .dout_signal_im(a_sig_im), .dout_signal_vld(a_sig_vld),
    .dout_payload_re(a_pld_re), .dout_payload_im(a_pld_im), .dout_payload_vld(a_pld_vld),
    .dout_sym_idx(a_idx), .frame_done(a_done), .err_sync(a_err), .busy(a_busy));

  ofdm_sym_demux #(.N_FFT(16), .HDR_SYMS(2), .DATA_MASK(16'hFFFE)) dut_b (
    .clk(clk), .rst(rst), .din_re(din_re), .din_im(din_im), .din_vld(din_vld),
    .din_sof(din_sof), .pld_nsym(pld_nsym),
    .dout_signal_re(b_sig_re), .dout_signal_im(b_sig_im), .dout_signal_vld(b_sig_vld),
    .dout_payload_re(b_pld_re), .dout_payload_im(b_pld_im), .dout_payload_vld(b_pld_vld),
    .dout_sym_idx(b_idx), .frame_done(b_done), .err_sync(b_err), .busy(b_busy));

  always #5 clk = ~clk;

  int   total = 0, bad = 0;
  int   cyc = 0, last_in = 0, bad_lat = 0;
  logic vld_d = 1'b0;
  rec_t sig_q[$], pld_q[$], sigb_q[$], pldb_q[$], exp_sig[$], exp_pld[$];
  int   done_q[$], err_q[$], sof_q[$], doneb_q[$];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    vld_d <= din_vld;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (a_sig_vld) sig_q.push_back({a_sig_re, a_sig_im, a_idx});
      if (a_pld_vld) pld_q.push_back({a_pld_re, a_pld_im, a_idx});
      if (b_sig_vld) sigb_q.push_back({b_sig_re, b_sig_im, b_idx});
      if (b_pld_vld) pldb_q.push_back({b_pld_re, b_pld_im, b_idx});
      if (!vld_d && (a_sig_vld || a_pld_vld)) bad_lat++;
      if (a_done) done_q.push_back(cyc);
      if (a_err)  err_q.push_back(cyc);
      if (b_done) doneb_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_data(int nfft, int b);
    if (nfft == 16) return b != 0;
    return !(b inside {0, 7, 21, [27:37], 43, 57});
  endfunction

  task automatic ex(input bit pld, input int nfft, input int nbins, input int im, input int idx);
    rec_t r;
    for (int b = 0; b < nbins; b++)
      if (is_data(nfft, b)) begin
        r.re = 12'(b); r.im = 12'(im); r.idx = 10'(idx);
        if (pld) exp_pld.push_back(r); else exp_sig.push_back(r);
      end
  endtask

  task automatic cmp_q(input string tag, input rec_t got[$], input rec_t exp[$]);
    chk({tag, "_cnt"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  task automatic clear();
    sig_q.delete(); pld_q.delete(); sigb_q.delete(); pldb_q.delete();
    exp_sig.delete(); exp_pld.delete();
    done_q.delete(); err_q.delete(); sof_q.delete(); doneb_q.delete();
    bad_lat = 0;
  endtask

  task automatic put(input int re, input int im, input bit sof, input int nsym, input bit tog);
    din_vld = 1'b1; din_sof = sof; din_re = 12'(re); din_im = 12'(im); pld_nsym = 10'(nsym);
    @(posedge clk); #1;
    last_in = cyc;
    if (sof) sof_q.push_back(cyc);
    if (tog) begin
      din_vld = 1'b0; din_sof = 1'b1; din_re = 12'hABC; din_im = 12'h5A5;
      @(posedge clk); #1;
    end
    din_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0; din_sof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int nfft, input int nsyms, input int nsym, input bit tog);
    for (int s = 0; s < nsyms; s++)
      for (int b = 0; b < nfft; b++)
        put(b, s, (s == 0 && b == 0), nsym, tog);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sig_vld"}, 64'(a_sig_vld), 0);
    chk({tag, "_pld_vld"}, 64'(a_pld_vld), 0);
    chk({tag, "_sig_data"}, 64'({a_sig_re, a_sig_im}), 0);
    chk({tag, "_pld_data"}, 64'({a_pld_re, a_pld_im}), 0);
    chk({tag, "_idx"}, 64'(a_idx), 0);
    chk({tag, "_flags"}, 64'({a_done, a_err, a_busy}), 0);
    chk({tag, "_b_flags"}, 64'({b_sig_vld, b_pld_vld, b_done, b_err, b_busy}), 0);
  endtask

  task automatic std_exp(input int nsym);
    ex(0, 64, 64, 0, 0);
    for (int p = 0; p < nsym; p++) ex(1, 64, 64, 1 + p, p);
  endtask

  initial begin
    rst = 1'b1; din_vld = 1'b0; din_sof = 1'b0; din_re = '0; din_im = '0; pld_nsym = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // T1: contiguous frame, two payload symbols
    clear();
    frame(64, 3, 2, 0);
    idle(3);
    std_exp(2);
    cmp_q("t1_sig", sig_q, exp_sig);
    cmp_q("t1_pld", pld_q, exp_pld);
    chk("t1_done_cnt", 64'(done_q.size()), 1);
    if (done_q.size() > 0) chk("t1_done_cyc", 64'(done_q[0]), 64'(last_in));
    chk("t1_err_cnt", 64'(err_q.size()), 0);
    chk("t1_latency", 64'(bad_lat), 0);
    chk("t1_busy", 64'(a_busy), 0);

    // T2: din_vld toggling, garbage and sof on the gap cycles
    clear();
    frame(64, 3, 2, 1);
    idle(3);
    std_exp(2);
    cmp_q("t2_sig", sig_q, exp_sig);
    cmp_q("t2_pld", pld_q, exp_pld);
    chk("t2_done_cnt", 64'(done_q.size()), 1);
    chk("t2_latency", 64'(bad_lat), 0);

    // T3: samples before sof are discarded
    clear();
    for (int i = 0; i < 100; i++) put(i % 64, 7, 0, 5, 0);
    idle(2);
    chk("t3_pre_outs", 64'(sig_q.size() + pld_q.size()), 0);
    chk("t3_pre_busy", 64'(a_busy), 0);
    frame(64, 2, 1, 0);
    idle(3);
    std_exp(1);
    cmp_q("t3_sig", sig_q, exp_sig);
    cmp_q("t3_pld", pld_q, exp_pld);
    chk("t3_done_cnt", 64'(done_q.size()), 1);

    // T4: sof at payload symbol 1 bin 30 aborts the frame
    clear();
    frame(64, 2, 3, 0);
    for (int b = 0; b < 30; b++) put(b, 2, 0, 3, 0);
    frame(64, 2, 1, 0);
    idle(3);
    std_exp(1);
    ex(1, 64, 30, 2, 1);
    std_exp(1);
    cmp_q("t4_sig", sig_q, exp_sig);
    cmp_q("t4_pld", pld_q, exp_pld);
    chk("t4_err_cnt", 64'(err_q.size()), 1);
    if (err_q.size() > 0 && sof_q.size() > 1) chk("t4_err_cyc", 64'(err_q[0]), 64'(sof_q[1]));
    chk("t4_done_cnt", 64'(done_q.size()), 1);
    if (done_q.size() > 0) chk("t4_done_cyc", 64'(done_q[0]), 64'(last_in));
    if (sig_q.size() > 48) chk("t4_first_new", 64'(sig_q[48]), 64'({12'd1, 12'd0, 10'd0}));

    // T5: unbounded payload ended by sof at a symbol boundary
    clear();
    frame(64, 4, 0, 0);
    frame(64, 2, 1, 0);
    idle(3);
    std_exp(3);
    std_exp(1);
    cmp_q("t5_sig", sig_q, exp_sig);
    cmp_q("t5_pld", pld_q, exp_pld);
    chk("t5_err_cnt", 64'(err_q.size()), 0);
    chk("t5_done_cnt", 64'(done_q.size()), 2);
    if (done_q.size() > 0 && sof_q.size() > 1) chk("t5_done_sof", 64'(done_q[0]), 64'(sof_q[1]));

    // T6: reset mid-payload, then samples without sof, then a clean frame
    clear();
    ex(0, 64, 64, 0, 0);
    ex(1, 64, 10, 1, 0);
    std_exp(1);
    for (int b = 0; b < 64; b++) put(b, 0, (b == 0), 2, 0);
    for (int b = 0; b < 10; b++) put(b, 1, 0, 2, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1 check_zero("t6_rst");
    repeat (2) @(posedge clk);
    #1 check_zero("t6_rst_hold");
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 50; i++) put(10 + i, 1, 0, 2, 0);
    idle(2);
    chk("t6_post_busy", 64'(a_busy), 0);
    chk("t6_post_outs", 64'(sig_q.size() + pld_q.size()), 56);
    frame(64, 2, 1, 0);
    idle(3);
    cmp_q("t6_sig", sig_q, exp_sig);
    cmp_q("t6_pld", pld_q, exp_pld);
    chk("t6_done_cnt", 64'(done_q.size()), 1);
    chk("t6_err_cnt", 64'(err_q.size()), 0);

    // T7: 16-bin instance with two SIGNAL symbols
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear();
    frame(16, 4, 2, 0);
    idle(3);
    ex(0, 16, 16, 0, 0);
    ex(0, 16, 16, 1, 1);
    ex(1, 16, 16, 2, 0);
    ex(1, 16, 16, 3, 1);
    cmp_q("t7_sig", sigb_q, exp_sig);
    cmp_q("t7_pld", pldb_q, exp_pld);
    chk("t7_done_cnt", 64'(doneb_q.size()), 1);
    if (doneb_q.size() > 0) chk("t7_done_cyc", 64'(doneb_q[0]), 64'(last_in));
    chk("t7_busy", 64'(b_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
